mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master, one-slave arbiter that shares the single data-memory port between the core's instruction-fetch requester (master 0, read-only) and its load/store requester (master 1). It sits between the core and memory, and replaces the fixed single-cycle memory assumption with a req/gnt/rvalid handshake. At most one transaction is outstanding at a time. Ties are resolved round-robin. An optional watchdog returns an error response if the slave never answers.

## Interface
Parameters:
- TIMEOUT, 255: RESP-state cycles without s_rvalid before an error response is returned (used only with the watchdog macro); legal range 1..65535.

Ports (clock: clock; reset: reset, asynchronous, active-high):
- clock  in  1  clock
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  fetch request; held stable until m0_gnt
- m0_addr  in  32  fetch address
- m0_gnt  out  1  fetch request accepted this cycle
- m0_rvalid  out  1  fetch response strobe, one cycle
- m0_rdata  out  32  fetch read data, valid with m0_rvalid
- m0_err  out  1  fetch response is an error, valid with m0_rvalid
- m1_req  in  1  data request; held stable until m1_gnt
- m1_we  in  1  1 = write, 0 = read
- m1_wstrb  in  2  width code: 00 byte, 01 half, 10 word, 11 reserved (passed through)
- m1_addr  in  32  data address
- m1_wdata  in  32  write data
- m1_gnt, m1_rvalid, m1_rdata[31:0], m1_err  out  same meaning as m0_*
- s_req  out  1  slave request
- s_we, s_wstrb[1:0], s_addr[31:0], s_wdata[31:0]  out  slave command; master-0 requests drive s_we=0, s_wstrb=10, s_wdata=0
- s_gnt  in  1  slave accepts s_req this cycle
- s_rvalid  in  1  slave response, at least 1 cycle after grant, exactly one per grant (reads and writes)
- s_rdata  in  32  slave read data

## Operation
- The FSM has three states: IDLE, ADDR (request presented, not yet granted, owner locked) and RESP (granted, awaiting response). Registers: state, owner (1 bit), last (1 bit, last granted master) and the watchdog counter.
- IDLE with no request: s_req=0 and state stays IDLE.
- IDLE, only one master requesting: that master wins.
- IDLE, both masters requesting: the master ≠ last wins.
- IDLE, winner selected: s_* is driven combinationally from the winner and s_req=1.
- IDLE, s_gnt=1: the winner's gnt=1; owner←winner, last←winner; go to RESP.
- IDLE, s_gnt=0: owner←winner; go to ADDR.
- ADDR: the slave command comes from owner, with s_req=1. A newly raised request from the other master cannot preempt. On s_gnt, owner's gnt=1, last←owner, and the FSM goes to RESP.
- RESP: s_req=0 and both gnt=0. On s_rvalid, owner's rvalid=1, rdata=s_rdata, err=0, and the FSM goes to IDLE.
- rdata outputs: a non-owner rdata is 0. Every rdata is 0 whenever its rvalid=0.
- s_rvalid in IDLE or ADDR is ignored; it is a slave protocol violation and is dropped.
- m*_gnt is a combinational path from s_gnt; the response outputs are combinational from s_rvalid/s_rdata.

## Timing
- Reset (async, any state): state=IDLE, owner=0, last=1 (fetch wins the first tie), counter=0. All outputs are 0 while reset is high.
- Zero-wait slave: request in cycle N is granted in cycle N. The response arrives no earlier than cycle N+1, and the next grant comes no earlier than the cycle after the response. Peak throughput is 1 transaction per 2 cycles.
- Simultaneous s_rvalid and a new req in RESP: the request is arbitrated in the following IDLE cycle.
- Both masters continuously requesting: grants alternate m0, m1, m0, …
- Reset during RESP abandons the transaction. No rvalid is produced, and a later s_rvalid is ignored.

## Configuration
- MEM_ARB_TIMEOUT_EN defined: a 16-bit counter clears on entry to RESP and increments each RESP cycle without s_rvalid.
  - On reaching TIMEOUT, owner's rvalid=1 and err=1, rdata=0, and the FSM goes to IDLE. Any later s_rvalid for that transaction is ignored.
  - s_rvalid in the same cycle as the timeout takes precedence (err=0).
- MEM_ARB_TIMEOUT_EN undefined: no counter, and RESP waits indefinitely. err outputs are tied to 0 and TIMEOUT is unused.

## Test plan
- Single read, zero-wait slave: m0_req, addr 0x100, with s_gnt=1 in cycle 0 and s_rvalid plus rdata 0xDEADBEEF in cycle 1.
  - Cycle 0: m0_gnt=1.
  - Cycle 1: m0_rvalid=1, m0_rdata=0xDEADBEEF, m1 outputs all 0.
- Tie after reset: m0_req and m1_req both held high for 4 transactions. Grants go m0, m1, m0, m1, and each s_addr matches the granted master.
- Lock in ADDR: m1 writes 0x55AA to 0x20 with wstrb=01, and s_gnt is held low for 3 cycles while m0_req rises.
  - During the wait, s_addr stays 0x20 and m0_gnt=0.
  - m1_gnt pulses on the 4th cycle.
- Stray s_rvalid in IDLE: m0_rvalid and m1_rvalid stay 0, and the state is unchanged.
- Watchdog: with MEM_ARB_TIMEOUT_EN and TIMEOUT=8, grant a read and never return s_rvalid.
  - 8 cycles after the grant: m1_rvalid=1, m1_err=1, m1_rdata=0.
  - The next m0 request is granted normally.
- Reset mid-RESP: assert reset 1 cycle after a grant, then return s_rvalid after release. All outputs are 0 during reset, no rvalid reaches either master, and the first tie afterwards is won by m0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master / one-slave memory port arbiter with req/gnt/rvalid handshake and round-robin tie break.
// Optional response watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        s_req,
    output logic        s_we,
    output logic [1:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_gnt,
    input  logic        s_rvalid,
    input  logic [31:0] s_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_q, last_d;
    logic   win_s, sel_s, req_s, grant_s, resp_s, err_s;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_s;
`endif

    // Arbitration: single requester wins, a tie goes to the master not granted last.
    always_comb begin
        win_s = 1'b0;
        if (m0_req && m1_req) begin
            win_s = ~last_q;
        end else if (m1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        sel_s = (state_q == ST_IDLE) ? win_s : owner_q;
`ifdef MEM_ARB_TIMEOUT_EN
        timeout_s = (state_q == ST_RESP) && !s_rvalid && (cnt_q == TO_LAST);
`endif
    end

    // Next-state logic; stray s_rvalid outside RESP simply falls through.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        req_s   = 1'b0;
        grant_s = 1'b0;
        resp_s  = 1'b0;
        err_s   = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    req_s   = 1'b1;
                    owner_d = win_s;
                    if (s_gnt) begin
                        grant_s = 1'b1;
                        last_d  = win_s;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                req_s = 1'b1;
                if (s_gnt) begin
                    grant_s = 1'b1;
                    last_d  = owner_q;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_RESP: begin
                if (s_rvalid) begin
                    resp_s  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
`ifdef MEM_ARB_TIMEOUT_EN
                    if (timeout_s) begin
                        resp_s  = 1'b1;
                        err_s   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 16'd1;
                        state_d = ST_RESP;
                    end
`else
                    state_d = ST_RESP;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef MEM_ARB_TIMEOUT_EN
        if (grant_s) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_d;
        end
`endif
    end

    // Output decode; everything is forced low while reset is asserted.
    always_comb begin
        s_req   = 1'b0;
        s_we    = 1'b0;
        s_wstrb = 2'b00;
        s_addr  = 32'h0000_0000;
        s_wdata = 32'h0000_0000;
        if (!reset && req_s) begin
            s_req = 1'b1;
            if (sel_s) begin
                s_we    = m1_we;
                s_wstrb = m1_wstrb;
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
            end else begin
                s_wstrb = 2'b10;
                s_addr  = m0_addr;
            end
        end else begin
            s_req = 1'b0;
        end
        m0_gnt    = !reset && grant_s && !sel_s;
        m1_gnt    = !reset && grant_s && sel_s;
        m0_rvalid = !reset && resp_s && !owner_q;
        m1_rvalid = !reset && resp_s && owner_q;
        m0_err    = m0_rvalid && err_s;
        m1_err    = m1_rvalid && err_s;
        m0_rdata  = (m0_rvalid && !err_s) ? s_rdata : 32'h0000_0000;
        m1_rdata  = (m1_rvalid && !err_s) ? s_rdata : 32'h0000_0000;
    end

    // State registers; fetch wins the first tie after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q   <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction model.
module tb_mem_arbiter;

    localparam int TO = 8;

    logic        clock, reset;
    logic        m0_req, m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_addr, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
    logic [1:0]  m1_wstrb;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        s_req, s_we, s_gnt, s_rvalid;
    logic [1:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata, s_rdata;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .m1_err(m1_err),
        .s_req(s_req), .s_we(s_we), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        m;
        logic [31:0] a;
        logic        we;
        logic [1:0]  ws;
        logic [31:0] wd;
    } gexp_t;
    typedef struct {
        logic        m;
        logic [31:0] d;
        logic        e;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int n_chk = 0;
    int n_fail = 0;

    // Transaction model: phase 0 = free, 1 = winner waiting for slave grant, 2 = awaiting response.
    int   ph = 0;
    logic mlast = 1'b1;
    logic mown = 1'b0;
    int   mcnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = 0; mlast = 1'b1; mown = 1'b0; mcnt = 0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_m0"}, {m0_gnt, m0_rvalid, m0_rdata, m0_err}, 128'd0);
        chk({tag, "_m1"}, {m1_gnt, m1_rvalid, m1_rdata, m1_err}, 128'd0);
        chk({tag, "_s"},  {s_req, s_we, s_wstrb, s_addr, s_wdata}, 128'd0);
    endtask

    // One clock cycle: drive inputs just after the edge and record what the arbiter must do.
    task automatic step(input logic m0r, input logic [31:0] m0a,
                        input logic m1r, input logic m1w, input logic [1:0] m1s,
                        input logic [31:0] m1a, input logic [31:0] m1d,
                        input logic sg, input logic srv, input logic [31:0] srd,
                        output logic g0, output logic g1);
        logic w;
        gexp_t g;
        @(posedge clock); #1;
        m0_req = m0r; m0_addr = m0a;
        m1_req = m1r; m1_we = m1w; m1_wstrb = m1s; m1_addr = m1a; m1_wdata = m1d;
        s_gnt = sg; s_rvalid = srv; s_rdata = srd;
        g0 = 1'b0; g1 = 1'b0;
        w = mown;
        if (ph == 0 && (m0r || m1r)) begin
            w = (m0r && m1r) ? ~mlast : m1r;
            mown = w;
            ph = 1;
        end
        if (ph == 1) begin
            if (sg) begin
                g.m  = w;
                g.a  = w ? m1a : m0a;
                g.we = w ? m1w : 1'b0;
                g.ws = w ? m1s : 2'b10;
                g.wd = w ? m1d : 32'd0;
                gq.push_back(g);
                mlast = w; ph = 2; mcnt = 0;
                if (w) g1 = 1'b1; else g0 = 1'b1;
            end
        end else if (ph == 2) begin
            if (srv) begin
                rq.push_back('{m: mown, d: srd, e: 1'b0});
                ph = 0;
            end else begin
`ifdef MEM_ARB_TIMEOUT_EN
                mcnt++;
                if (mcnt == TO) begin
                    rq.push_back('{m: mown, d: 32'd0, e: 1'b1});
                    ph = 0;
                end
`endif
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m0_req = 1'b0; m0_addr = 32'd0; m1_req = 1'b0; m1_we = 1'b0; m1_wstrb = 2'b00;
        m1_addr = 32'd0; m1_wdata = 32'd0; s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = 32'd0;
        model_reset();
        repeat (2) @(negedge clock);
        chk_outputs_zero("reset");
        reset = 1'b0;
    endtask

    // Monitor: compare every grant and response the DUT presents against the queues.
    always @(negedge clock) begin
        gexp_t g;
        rexp_t r;
        if (!reset) begin
            if (m0_gnt || m1_gnt) begin
                if (gq.size() == 0) begin
                    chk("unexpected_grant", {m1_gnt, m0_gnt}, 128'd0);
                end else begin
                    g = gq.pop_front();
                    chk("gnt_master", {m1_gnt, m0_gnt}, g.m ? 128'd2 : 128'd1);
                    chk("gnt_cmd", {s_req, s_we, s_wstrb, s_addr, s_wdata}, {1'b1, g.we, g.ws, g.a, g.wd});
                end
            end else begin
                chk("missing_grant", 128'(gq.size()), 128'd0);
                gq.delete();
            end
            if (m0_rvalid || m1_rvalid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rvalid", {m1_rvalid, m0_rvalid}, 128'd0);
                end else begin
                    r = rq.pop_front();
                    chk("rsp_master", {m1_rvalid, m0_rvalid}, r.m ? 128'd2 : 128'd1);
                    if (r.m)
                        chk("rsp_m1", {m1_rdata, m1_err, m0_rdata, m0_err}, {r.d, r.e, 32'd0, 1'b0});
                    else
                        chk("rsp_m0", {m0_rdata, m0_err, m1_rdata, m1_err}, {r.d, r.e, 32'd0, 1'b0});
                end
            end else begin
                chk("missing_rvalid", 128'(rq.size()), 128'd0);
                rq.delete();
                chk("idle_rdata", {m0_rdata, m0_err, m1_rdata, m1_err}, 128'd0);
            end
        end
    end

    initial begin
        logic g0, g1;
        logic p0, p1, p1w, outst;
        logic [1:0] p1s;
        logic [31:0] p0a, p1a, p1d;
        int wt, ncyc;

        do_reset();

        // Single read with a zero-wait slave.
        step(1'b1, 32'h100, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, g0, g1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'hDEADBEEF, g0, g1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, g0, g1);

        // Both masters requesting continuously must alternate m0, m1, m0, m1.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h1000 + 32'(i), 1'b1, 1'b0, 2'b10, 32'h2000 + 32'(i), 32'd0,
                 1'b1, 1'b0, 32'd0, g0, g1);
            chk("tie_order", {g1, g0}, (i % 2 == 0) ? 128'd1 : 128'd2);
            step(1'b1, 32'h1000 + 32'(i), 1'b1, 1'b0, 2'b10, 32'h2000 + 32'(i), 32'd0,
                 1'b1, 1'b1, 32'hA000 + 32'(i), g0, g1);
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, g0, g1);

        // Owner stays locked while the slave stalls; stray s_rvalid in IDLE is dropped.
        step(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'h1234, g0, g1);
        for (int i = 0; i < 3; i++) begin
            step(i > 0, 32'h300, 1'b1, 1'b1, 2'b01, 32'h20, 32'h55AA, 1'b0, 1'b0, 32'd0, g0, g1);
            @(negedge clock);
            chk("lock_addr", {s_req, s_addr, m0_gnt, m1_gnt}, {1'b1, 32'h20, 2'b00});
        end
        step(1'b1, 32'h300, 1'b1, 1'b1, 2'b01, 32'h20, 32'h55AA, 1'b1, 1'b0, 32'd0, g0, g1);
        step(1'b1, 32'h300, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, g0, g1);
        step(1'b1, 32'h300, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'h0, g0, g1);
        step(1'b1, 32'h300, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, g0, g1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'h7777, g0, g1);

`ifdef MEM_ARB_TIMEOUT_EN
        // Slave never answers: error response after TO cycles, then normal service.
        step(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 32'h400, 32'd0, 1'b1, 1'b0, 32'd0, g0, g1);
        for (int i = 0; i < TO; i++)
            step(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, g0, g1);
        step(1'b1, 32'h500, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1, 32'hBAD, g0, g1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'hC0DE, g0, g1);
`endif

        // Reset in RESP abandons the transaction; m0 wins the first tie afterwards.
        step(1'b1, 32'h600, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, g0, g1);
        @(posedge clock); #2;
        reset = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1; s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = 32'hFFFF;
        model_reset();
        repeat (2) begin
            @(negedge clock);
            chk_outputs_zero("mid_resp_reset");
        end
        m0_req = 1'b0; m1_req = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b0;
        reset = 1'b0;
        step(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'h9999, g0, g1);
        step(1'b1, 32'h700, 1'b1, 1'b0, 2'b00, 32'h800, 32'd0, 1'b1, 1'b0, 32'd0, g0, g1);
        chk("post_reset_tie", {g1, g0}, 128'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 2'b00, 32'h800, 32'd0, 1'b0, 1'b1, 32'h4444, g0, g1);

        // Randomized traffic; requests held until the model grants them.
        p0 = 1'b0; p1 = 1'b1; p0a = 32'd0; p1a = 32'h800; p1w = 1'b0; p1s = 2'b00; p1d = 32'd0;
        outst = 1'b0; wt = 0; ncyc = 0;
        while (ncyc < 450 && (ncyc < 400 || p0 || p1 || outst)) begin
            logic srv, sg;
            if (ncyc < 400 && !p0 && ($urandom % 3 == 0)) begin
                p0 = 1'b1; p0a = $urandom;
            end
            if (ncyc < 400 && !p1 && ($urandom % 3 == 0)) begin
                p1 = 1'b1; p1a = $urandom; p1w = 1'($urandom); p1s = 2'($urandom); p1d = $urandom;
            end
            sg = 1'($urandom_range(0, 1));
            if (outst) begin
                wt--;
                srv = (wt == 0);
                if (srv) outst = 1'b0;
            end else begin
                srv = ($urandom % 20 == 0);
            end
            step(p0, p0a, p1, p1w, p1s, p1a, p1d, sg, srv, $urandom, g0, g1);
            if (g0) p0 = 1'b0;
            if (g1) p1 = 1'b0;
            if (g0 || g1) begin
                outst = 1'b1; wt = $urandom_range(1, 3);
            end
            ncyc++;
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, g0, g1);
        @(negedge clock);
        #1;
        chk("queues_drained", {32'(gq.size()), 32'(rq.size())}, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
